// File: rtl/parking_sensor_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : parking_sensor_conditioner_if
// Description : Raw loop-sensor inputs and conditioned event outputs of the
//               parking sensor front end. The master modport is the
//               conditioner itself; the slave modport is the sensor/consumer
//               side that drives the raw inputs and observes the events.
// Revision    : 1.0 - initial release
// ============================================================================
interface parking_sensor_conditioner_if;
  logic       entry_raw;
  logic       exit_raw;
  logic       sense_entry;
  logic       sense_exit;
  logic [1:0] entry_pending;
  logic [1:0] exit_pending;
  logic       overflow;

  modport master (
    input  entry_raw,
    input  exit_raw,
    output sense_entry,
    output sense_exit,
    output entry_pending,
    output exit_pending,
    output overflow
  );

  modport slave (
    output entry_raw,
    output exit_raw,
    input  sense_entry,
    input  sense_exit,
    input  entry_pending,
    input  exit_pending,
    input  overflow
  );
endinterface
`default_nettype wire

// File: rtl/parking_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : parking_sensor_conditioner
// Description : Synchronises and debounces the entry/exit loop sensors, turns
//               each qualified arrival into one single-cycle event pulse,
//               queues up to three events per direction and spaces pulses by
//               a programmable idle gap with alternating exit/entry priority.
//               Build option PARK_SENSE_SYNC_EN: when defined, a 2-flop
//               synchroniser precedes each debouncer (production build).
// Revision    : 1.0 - initial release
// ============================================================================
module parking_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  parking_sensor_conditioner_if.master  bus
);

  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_DB_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYCLES - 1);

  // Index 0 is the entry direction, index 1 the exit direction.
  logic [1:0] w_raw;
  logic [1:0] w_pend [2];
  logic [1:0] w_issue;
  logic [1:0] w_drop;

  assign w_raw = {bus.exit_raw, bus.entry_raw};

  for (genvar gi = 0; gi < 2; gi++) begin : g_dir
    logic               w_in;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_filt;
    logic               r_filt_d;
    logic               w_event;
    logic [1:0]         r_pend;

`ifdef PARK_SENSE_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchroniser for the asynchronous loop-sensor input.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= w_raw[gi];
        r_sync2 <= r_sync1;
      end
    end

    assign w_in = r_sync2;
`else
    assign w_in = w_raw[gi];
`endif

    // Debounce: the filtered level only follows a run of DEBOUNCE_CYCLES differing samples.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt  <= '0;
        r_filt <= 1'b0;
      end else if (w_in == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == c_DB_LAST) begin
        r_filt <= w_in;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end

    // Previous filtered level, used to spot the arrival (rising) edge.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_filt_d <= 1'b0;
      end else begin
        r_filt_d <= r_filt;
      end
    end

    assign w_event = r_filt & ~r_filt_d;

    // Pending queue depth: +1 per arrival, -1 per issue, saturating at 3.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_pend <= 2'd0;
      end else if (w_event && !w_issue[gi]) begin
        if (r_pend != 2'd3) begin
          r_pend <= r_pend + 2'd1;
        end
      end else if (!w_event && w_issue[gi]) begin
        r_pend <= r_pend - 2'd1;
      end
    end

    // An arrival that finds a full queue with nothing leaving is lost.
    assign w_drop[gi] = w_event & ~w_issue[gi] & (r_pend == 2'd3);
    assign w_pend[gi] = r_pend;
  end : g_dir

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_GAP_W-1:0] r_gap;
  logic [c_GAP_W-1:0] w_gap_nxt;
  logic               r_sel_exit;
  logic               w_sel_exit_nxt;
  logic               r_prio_exit;
  logic               w_prio_exit_nxt;
  logic               r_sense_entry;
  logic               r_sense_exit;
  logic               w_sense_entry_nxt;
  logic               w_sense_exit_nxt;
  logic               r_overflow;
  logic               w_any;
  logic               w_pick_exit;

  assign w_any       = (w_pend[0] != 2'd0) || (w_pend[1] != 2'd0);
  // Exit wins when it is the only one waiting or when it holds priority.
  assign w_pick_exit = (w_pend[1] != 2'd0) && ((w_pend[0] == 2'd0) || r_prio_exit);

  // Issue FSM state, gap timer, selection, priority and the registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_gap         <= '0;
      r_sel_exit    <= 1'b0;
      r_prio_exit   <= 1'b1;
      r_sense_entry <= 1'b0;
      r_sense_exit  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_gap         <= w_gap_nxt;
      r_sel_exit    <= w_sel_exit_nxt;
      r_prio_exit   <= w_prio_exit_nxt;
      r_sense_entry <= w_sense_entry_nxt;
      r_sense_exit  <= w_sense_exit_nxt;
    end
  end

  // Next-state logic: pick a direction in IDLE, consume it in ISSUE, then idle for the gap.
  always_comb begin
    w_state_nxt       = r_state;
    w_gap_nxt         = r_gap;
    w_sel_exit_nxt    = r_sel_exit;
    w_prio_exit_nxt   = r_prio_exit;
    w_sense_entry_nxt = 1'b0;
    w_sense_exit_nxt  = 1'b0;
    w_issue           = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt       = ST_ISSUE;
          w_sel_exit_nxt    = w_pick_exit;
          w_prio_exit_nxt   = ~w_pick_exit;
          w_sense_exit_nxt  = w_pick_exit;
          w_sense_entry_nxt = ~w_pick_exit;
        end
      end
      ST_ISSUE: begin
        w_issue     = r_sel_exit ? 2'b10 : 2'b01;
        w_gap_nxt   = c_GAP_LOAD;
        w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (r_gap == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap - c_GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sticky record that some arrival was lost to a full queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (|w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.sense_entry   = r_sense_entry;
  assign bus.sense_exit    = r_sense_exit;
  assign bus.entry_pending = w_pend[0];
  assign bus.exit_pending  = w_pend[1];
  assign bus.overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_parking_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_sensor_conditioner
// Description : Self-checking bench for parking_sensor_conditioner. Two
//               instances (default and fast-debounce/long-gap) see the same
//               sensor stimulus; a behavioural model derives the expected
//               pulses, queue depths and overflow flag from the sample
//               history and an issue-time schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_sensor_conditioner;
  localparam int D0 = 4;
  localparam int G0 = 2;
  localparam int D1 = 2;
  localparam int G1 = 8;
`ifdef PARK_SENSE_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int MAXN = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  parking_sensor_conditioner_if if0 ();
  parking_sensor_conditioner_if if1 ();

  parking_sensor_conditioner #(.DEBOUNCE_CYCLES(D0), .GAP_CYCLES(G0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.master)
  );

  parking_sensor_conditioner #(.DEBOUNCE_CYCLES(D1), .GAP_CYCLES(G1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.master)
  );

  always #5 clk = ~clk;

  logic [6:0] obs0;
  logic [6:0] obs1;
  assign obs0 = {if0.sense_entry, if0.sense_exit, if0.entry_pending, if0.exit_pending, if0.overflow};
  assign obs1 = {if1.sense_entry, if1.sense_exit, if1.entry_pending, if1.exit_pending, if1.overflow};

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  bit hist [2][MAXN];          // raw samples since reset release, per direction
  bit m_filt  [2][2];
  bit m_rise  [2][2];
  bit m_pulse [2][2];
  int m_pend  [2][2];
  bit m_ovf   [2];
  bit m_prio_exit [2];
  int m_dec   [2];
  int m_next_ok [2];
  int m_n;

  function automatic int dget(input int k);
    return (k == 0) ? D0 : D1;
  endfunction

  function automatic int gget(input int k);
    return (k == 0) ? G0 : G1;
  endfunction

  function automatic logic [6:0] obs(input int k);
    return (k == 0) ? obs0 : obs1;
  endfunction

  function automatic logic [6:0] exp_vec(input int k);
    return {m_pulse[k][0], m_pulse[k][1], 2'(m_pend[k][0]), 2'(m_pend[k][1]), m_ovf[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < 2; d++) begin
        m_filt[k][d]  = 1'b0;
        m_rise[k][d]  = 1'b0;
        m_pulse[k][d] = 1'b0;
        m_pend[k][d]  = 0;
      end
      m_ovf[k]       = 1'b0;
      m_prio_exit[k] = 1'b1;
      m_dec[k]       = -1;
      m_next_ok[k]   = 0;
    end
    m_n = 0;
  endtask

  // Expected state after edge m_n given the raw sample (e,x) taken at that edge.
  task automatic model_step(input bit e, input bit x);
    bit ev [2];
    bit flip;
    bit s;
    int idx;
    int dec;
    int pick;
    if (m_n >= MAXN) begin
      $display("FAIL model_history: edge %0d exceeds %0d", m_n, MAXN);
      $fatal(1);
    end
    hist[0][m_n] = e;
    hist[1][m_n] = x;
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < 2; d++) begin
        flip = 1'b1;
        for (int j = 0; j < dget(k); j++) begin
          idx = m_n - j - SYNC;
          s   = (idx >= 0) ? hist[d][idx] : 1'b0;
          if (s == m_filt[k][d]) flip = 1'b0;
        end
        ev[d]        = m_rise[k][d];
        m_rise[k][d] = flip && !m_filt[k][d];
        if (flip) m_filt[k][d] = !m_filt[k][d];
      end
      dec = m_dec[k];
      m_dec[k] = -1;
      m_pulse[k][0] = 1'b0;
      m_pulse[k][1] = 1'b0;
      if (m_n >= m_next_ok[k] && (m_pend[k][0] != 0 || m_pend[k][1] != 0)) begin
        pick = (m_pend[k][1] != 0 && (m_pend[k][0] == 0 || m_prio_exit[k])) ? 1 : 0;
        m_pulse[k][pick] = 1'b1;
        m_dec[k]         = pick;
        m_next_ok[k]     = m_n + gget(k) + 2;
        m_prio_exit[k]   = (pick == 0);
      end
      for (int d = 0; d < 2; d++) begin
        if (ev[d] && dec == d) begin
          // arrival and departure cancel
        end else if (ev[d]) begin
          if (m_pend[k][d] == 3) m_ovf[k] = 1'b1;
          else m_pend[k][d]++;
        end else if (dec == d) begin
          m_pend[k][d]--;
        end
      end
    end
    m_n++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit e, input bit x);
    if0.entry_raw = e;
    if0.exit_raw  = x;
    if1.entry_raw = e;
    if1.exit_raw  = x;
  endtask

  task automatic cycle(input bit e, input bit x);
    drive(e, x);
    @(posedge clk);
    model_step(e, x);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs(k) !== 7'd0) begin
        n_err++;
        $display("FAIL reset_assert inst%0d: got %b want %b", k, obs(k), 7'd0);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL reset_idle inst%0d edge %0d: got %b want %b", k, m_n - 1, obs(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_single_entry();
    int t0;
    int pedge;
    int npulse;
    bit exit_seen;
    apply_reset();
    t0 = m_n; pedge = -1; npulse = 0; exit_seen = 1'b0;
    for (int i = 0; i < 35; i++) begin
      cycle(i < 20, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL single_entry inst%0d edge %0d: got %b want %b", k, m_n - 1, obs(k), exp_vec(k));
        end
      end
      if (if0.sense_entry) begin
        npulse++;
        if (pedge < 0) pedge = m_n - 1;
      end
      if (if0.sense_exit) exit_seen = 1'b1;
    end
    n_cmp++;
    if (npulse !== 1) begin
      n_err++;
      $display("FAIL single_entry_count: got %0d pulses want 1", npulse);
    end
    n_cmp++;
    if (pedge - t0 !== D0 + 1 + SYNC) begin
      n_err++;
      $display("FAIL single_entry_latency: got %0d edges want %0d", pedge - t0, D0 + 1 + SYNC);
    end
    n_cmp++;
    if (exit_seen !== 1'b0) begin
      n_err++;
      $display("FAIL single_entry_no_exit: got %b want 0", exit_seen);
    end
  endtask

  task automatic test_glitch();
    int npulse;
    bit pend_seen;
    apply_reset();
    npulse = 0; pend_seen = 1'b0;
    for (int i = 0; i < 23; i++) begin
      cycle(1'b0, i < 3);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL glitch inst%0d edge %0d: got %b want %b", k, m_n - 1, obs(k), exp_vec(k));
        end
      end
      if (if0.sense_entry || if0.sense_exit) npulse++;
      if (if0.entry_pending != 2'd0 || if0.exit_pending != 2'd0) pend_seen = 1'b1;
    end
    n_cmp++;
    if (npulse !== 0 || pend_seen !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_reject: got %0d pulses pend_seen=%b want 0 pulses pend_seen=0", npulse, pend_seen);
    end
  endtask

  task automatic test_simultaneous();
    int ex_e;
    int en_e;
    bit overlap;
    apply_reset();
    ex_e = -1; en_e = -1; overlap = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cycle(i < 12, i < 12);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL simultaneous inst%0d edge %0d: got %b want %b", k, m_n - 1, obs(k), exp_vec(k));
        end
      end
      if (if0.sense_exit && ex_e < 0) ex_e = m_n - 1;
      if (if0.sense_entry && en_e < 0) en_e = m_n - 1;
      if ((if0.sense_entry && if0.sense_exit) || (if1.sense_entry && if1.sense_exit)) overlap = 1'b1;
    end
    n_cmp++;
    if (ex_e < 0 || en_e - ex_e !== G0 + 2) begin
      n_err++;
      $display("FAIL simultaneous_order: exit edge %0d entry edge %0d, want entry %0d after exit", ex_e, en_e, G0 + 2);
    end
    n_cmp++;
    if (overlap !== 1'b0) begin
      n_err++;
      $display("FAIL simultaneous_overlap: got %b want 0", overlap);
    end
  endtask

  task automatic test_overflow();
    int ovf_pend;
    int en_cnt;
    int ex_cnt;
    apply_reset();
    ovf_pend = -1; en_cnt = 0; ex_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      cycle((i % 4) < 2 && i < 32, (i % 4) < 2 && i < 16);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL overflow inst%0d edge %0d: got %b want %b", k, m_n - 1, obs(k), exp_vec(k));
        end
      end
      if (if1.overflow && ovf_pend < 0) ovf_pend = int'(if1.entry_pending);
      if (if1.sense_entry) en_cnt++;
      if (if1.sense_exit) ex_cnt++;
    end
    n_cmp++;
    if (ovf_pend !== 3) begin
      n_err++;
      $display("FAIL overflow_depth: got entry_pending %0d at flag set want 3", ovf_pend);
    end
    n_cmp++;
    if (if1.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_sticky: got %b want 1", if1.overflow);
    end
    n_cmp++;
    if (en_cnt !== 4 || ex_cnt !== 4) begin
      n_err++;
      $display("FAIL overflow_pulses: got entry %0d exit %0d want entry 4 exit 4", en_cnt, ex_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    int npulse;
    apply_reset();
    hit = 1'b0; npulse = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      cycle(1'b0, (i % 4) < 2);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL reset_mid_pre inst%0d edge %0d: got %b want %b", k, m_n - 1, obs(k), exp_vec(k));
        end
      end
      if (m_pend[1][1] == 2 && m_dec[1] < 0 && (m_n - 1) < m_next_ok[1] - 1) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL reset_mid_setup: got no gap with exit_pending=2 within 60 cycles want one");
    end
    rst = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs(k) !== 7'd0) begin
        n_err++;
        $display("FAIL reset_mid_clear inst%0d: got %b want %b", k, obs(k), 7'd0);
      end
    end
    drive(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL reset_mid_post inst%0d edge %0d: got %b want %b", k, m_n - 1, obs(k), exp_vec(k));
        end
      end
      if (if0.sense_entry || if0.sense_exit || if1.sense_entry || if1.sense_exit) npulse++;
    end
    n_cmp++;
    if (npulse !== 0) begin
      n_err++;
      $display("FAIL reset_mid_quiet: got %0d pulses want 0", npulse);
    end
  endtask

  task automatic test_held_through_reset();
    int npulse;
    drive(1'b1, 1'b0);
    apply_reset();
    npulse = 0;
    for (int i = 0; i < 35; i++) begin
      cycle(i < 25, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL held_reset inst%0d edge %0d: got %b want %b", k, m_n - 1, obs(k), exp_vec(k));
        end
      end
      if (if0.sense_entry) npulse++;
    end
    n_cmp++;
    if (npulse !== 1) begin
      n_err++;
      $display("FAIL held_reset_count: got %0d pulses want 1", npulse);
    end
  endtask

  task automatic test_random();
    bit lvl [2];
    int run [2];
    bit overlap;
    apply_reset();
    lvl[0] = 1'b0; lvl[1] = 1'b0; run[0] = 0; run[1] = 0; overlap = 1'b0;
    for (int i = 0; i < 500; i++) begin
      for (int d = 0; d < 2; d++) begin
        if (run[d] == 0) begin
          lvl[d] = 1'($urandom_range(0, 1));
          run[d] = int'($urandom_range(1, 10));
        end
        run[d]--;
      end
      cycle(lvl[0], lvl[1]);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL random inst%0d edge %0d: got %b want %b", k, m_n - 1, obs(k), exp_vec(k));
        end
      end
      if ((if0.sense_entry && if0.sense_exit) || (if1.sense_entry && if1.sense_exit)) overlap = 1'b1;
    end
    n_cmp++;
    if (overlap !== 1'b0) begin
      n_err++;
      $display("FAIL random_overlap: got %b want 0", overlap);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_entry();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    test_held_through_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
